// File: rtl/vau_pkg.sv
// Shared types and constants for the vector ALU op sequencer.
// Optional build macro: VAU_CYCLE_COUNT_EN (adds a busy-cycle counter output).
package vau_pkg;

    localparam int MAX_DIM = 12;                          // largest legal row/column count
    localparam int ADDR_W  = 8;                           // operand/result memory address width
    localparam int NUM_OPS = 10;                          // legal opcodes are 0..NUM_OPS-1
    localparam int TIMEOUT = 64;                          // max WAIT cycles before error
    localparam int IDX_W   = $clog2(MAX_DIM * MAX_DIM);   // linear element index width
    localparam int WAIT_W  = $clog2(TIMEOUT);             // WAIT cycle counter width

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MIN = 4'd6;
    localparam logic [3:0] OP_MAX = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_LDA,
        ST_LDB,
        ST_EXEC,
        ST_WAIT,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_t;

    // A command is runnable when both dimensions are 1..MAX_DIM and the opcode exists.
    function automatic logic cmd_is_valid(logic [3:0] op, logic [3:0] rows, logic [3:0] cols);
        return (rows != 4'd0) && (rows <= 4'(MAX_DIM)) &&
               (cols != 4'd0) && (cols <= 4'(MAX_DIM)) &&
               (op < 4'(NUM_OPS));
    endfunction

endpackage

// File: rtl/vau_elem_counter.sv
// Row-major element walker: row/col counters plus a linear index, with a
// flag marking the final element of the current matrix.
module vau_elem_counter
    import vau_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic [3:0]       rows,
    input  logic [3:0]       cols,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [3:0] row;
    logic [3:0] col;

    // Last element is the bottom-right corner of the rows x cols matrix.
    assign last = (row == rows - 4'd1) && (col == cols - 4'd1);

    // Advance column first, wrapping into the next row; idx just counts elements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= 4'd0;
            col <= 4'd0;
            idx <= '0;
        end else if (clear) begin
            row <= 4'd0;
            col <= 4'd0;
            idx <= '0;
        end else if (step) begin
            idx <= idx + IDX_W'(1);
            if (col == cols - 4'd1) begin
                col <= 4'd0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end

endmodule

// File: rtl/vau_op_sequencer.sv
// Command-driven sequencer that walks one element-wise matrix operation through
// the vector ALU: clear, load A, load B, execute, wait, write back per element.
// Handshake: a command is taken on any rising clock edge where cmd_valid and
// cmd_ready are both high; all command fields are captured on that edge and
// cmd_ready stays low until the sequencer is back in IDLE.
// Optional build macro: VAU_CYCLE_COUNT_EN adds cycle_count[31:0].
module vau_op_sequencer
    import vau_pkg::*;
(
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [3:0]        cmd_rows,
    input  logic [3:0]        cmd_cols,
    input  logic [ADDR_W-1:0] cmd_base_a,
    input  logic [ADDR_W-1:0] cmd_base_b,
    input  logic [ADDR_W-1:0] cmd_base_c,
    input  logic              abort,
    output logic              alu_rst,
    output logic              alu_operand_sel,
    output logic              alu_load,
    output logic [3:0]        alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef VAU_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    state_t state;
    state_t state_nxt;

    logic [3:0]        op_q;
    logic [3:0]        rows_q;
    logic [3:0]        cols_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] base_c_q;
    logic              recover_q;   // CLR is the post-error cleanup pass
    logic [WAIT_W-1:0] wait_cnt;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic              accept;
    logic              step;

    assign accept = cmd_valid && cmd_ready;
    // An aborted write-back must not advance the element walk.
    assign step   = (state == ST_WR) && !abort;

    vau_elem_counter u_elem (
        .clk   (wb_clk_i),
        .rst_n (rst_n),
        .clear (accept),
        .step  (step),
        .rows  (rows_q),
        .cols  (cols_q),
        .idx   (idx),
        .last  (last)
    );

    // State register.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Capture command fields on accept.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 4'd0;
            rows_q   <= 4'd0;
            cols_q   <= 4'd0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
        end else if (accept) begin
            op_q     <= cmd_op;
            rows_q   <= cmd_rows;
            cols_q   <= cmd_cols;
            base_a_q <= cmd_base_a;
            base_b_q <= cmd_base_b;
            base_c_q <= cmd_base_c;
        end
    end

    // Remember that the next CLR is cleanup after ERR and leads back to IDLE.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n)                  recover_q <= 1'b0;
        else if (state == ST_ERR)    recover_q <= 1'b1;
        else if (state == ST_CLR)    recover_q <= 1'b0;
    end

    // Count cycles spent in WAIT for the current element.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n)                  wait_cnt <= '0;
        else if (state == ST_WAIT)   wait_cnt <= wait_cnt + WAIT_W'(1);
        else                         wait_cnt <= '0;
    end

    // Next-state logic; abort takes priority over every other exit.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)
                         state_nxt = cmd_is_valid(cmd_op, cmd_rows, cmd_cols) ? ST_CLR : ST_ERR;
            ST_CLR:  if (recover_q)  state_nxt = ST_IDLE;
                     else if (abort) state_nxt = ST_ERR;
                     else            state_nxt = ST_LDA;
            ST_LDA:  state_nxt = abort ? ST_ERR : ST_LDB;
            ST_LDB:  state_nxt = abort ? ST_ERR : ST_EXEC;
            ST_EXEC: state_nxt = abort ? ST_ERR : ST_WAIT;
            ST_WAIT: if (abort)                                 state_nxt = ST_ERR;
                     else if (alu_done)                         state_nxt = ST_WR;
                     else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) state_nxt = ST_ERR;
            ST_WR:   if (abort)     state_nxt = ST_ERR;
                     else if (last) state_nxt = ST_DONE;
                     else           state_nxt = ST_LDA;
            ST_DONE: state_nxt = abort ? ST_ERR : ST_IDLE;
            ST_ERR:  state_nxt = ST_CLR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state ALU / memory controls; the ALU is held in reset while rst_n is low.
    always_comb begin
        cmd_ready       = rst_n && (state == ST_IDLE);
        busy            = (state != ST_IDLE);
        alu_rst         = !rst_n || (state == ST_CLR);
        alu_op          = busy ? op_q : 4'd0;
        alu_operand_sel = 1'b0;
        alu_load        = 1'b0;
        alu_start       = 1'b0;
        mem_addr        = '0;
        mem_we          = 1'b0;
        done            = (state == ST_DONE);
        err             = (state == ST_ERR);
        unique case (state)
            ST_LDA: begin
                alu_load = 1'b1;
                mem_addr = base_a_q + ADDR_W'(idx);
            end
            ST_LDB: begin
                alu_operand_sel = 1'b1;
                alu_load        = 1'b1;
                mem_addr        = base_b_q + ADDR_W'(idx);
            end
            ST_EXEC: alu_start = 1'b1;
            ST_WR: begin
                mem_we   = !abort;
                mem_addr = base_c_q + ADDR_W'(idx);
            end
            default: ;
        endcase
    end

`ifdef VAU_CYCLE_COUNT_EN
    logic cnt_run;

    // Busy-cycle counter: restarts on accept, stops after DONE/ERR, saturates.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= 32'd0;
            cnt_run     <= 1'b0;
        end else if (accept) begin
            cycle_count <= 32'd0;
            cnt_run     <= 1'b1;
        end else if (cnt_run) begin
            if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
            if (state == ST_DONE || state == ST_ERR) cnt_run <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/vau_op_sequencer.md
Name: vau_op_sequencer

Overview:
Command-driven controller that sequences the vector accelerator ALU through one element-wise matrix operation (up to 12x12) per command. Accepts a command (opcode, dimensions, base addresses) from the Wishbone-side register block. Walks row/column counters and drives the ALU flag interface (ALU reset, operand select, operation code) plus operand/result memory addresses. Sits between the user-project register file and the vector ALU datapath inside user_proj_example.

Parameters:
MAX_DIM, 12, largest legal row/column count
ADDR_W, 8, operand/result memory address width
NUM_OPS, 10, legal opcodes are 0..NUM_OPS-1
TIMEOUT, 64, max cycles waiting for alu_done before error

Ports:
wb_clk_i  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_op  in  4  ALU operation code
cmd_rows  in  4  row count, 1..MAX_DIM
cmd_cols  in  4  column count, 1..MAX_DIM
cmd_base_a  in  ADDR_W  operand A base address
cmd_base_b  in  ADDR_W  operand B base address
cmd_base_c  in  ADDR_W  result base address
abort  in  1  synchronous abort of current command
alu_rst  out  1  ALU reset flag (active high)
alu_operand_sel  out  1  0 = load A, 1 = load B
alu_load  out  1  operand load strobe
alu_op  out  4  operation code to ALU
alu_start  out  1  one-cycle execute strobe
alu_done  in  1  ALU result valid
mem_addr  out  ADDR_W  operand read / result write address
mem_we  out  1  result write strobe
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in IDLE after release; alu_rst=1; all other outputs 0.
- Clock reaches both the ALU and the sequencer; all state updates on rising wb_clk_i. Reset deasserts asynchronously, has no synchronizer inside, and is used as-is.
- Handshake: command accepted on cycle where cmd_valid & cmd_ready. All fields latched then; cmd_ready=0 until return to IDLE.
- Validation at accept: rows or cols equal to 0 or >MAX_DIM, or cmd_op>=NUM_OPS -> go to ERR. No ALU or memory activity.
- FSM: IDLE -> CLR (alu_rst=1, 1 cycle) -> LDA (alu_operand_sel=0, alu_load=1, mem_addr=base_a+idx) -> LDB (alu_operand_sel=1, alu_load=1, mem_addr=base_b+idx) -> EXEC (alu_start=1 for 1 cycle) -> WAIT (hold until alu_done) -> WR (mem_we=1, mem_addr=base_c+idx). Then LDA for the next element, or DONE after the last element. DONE pulses done and returns to IDLE. ERR pulses err and returns to IDLE through CLR.
- alu_op holds the latched opcode from accept until IDLE.
- Element order is row-major. col increments 0..cols-1 and wraps to 0 with row++. idx is a linear counter incremented in WR (no multiplier). The last element is row=rows-1, col=cols-1.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent and not an error.
- Latency per element: 5 cycles plus ALU latency. Total = 1 (CLR) + N*(5+L) + 1 (DONE).
- WAIT timeout: TIMEOUT cycles without alu_done -> ERR.
- alu_done outside WAIT is ignored.
- abort in any non-IDLE state -> ERR on the next cycle. abort wins over a simultaneous alu_done or the last WR. mem_we is suppressed in the abort cycle.
- busy=1 in every state except IDLE.

Optional Feature:
VAU_CYCLE_COUNT_EN:
- When defined, adds output cycle_count[31:0]. The counter clears at command accept and increments every cycle while busy. It freezes at DONE/ERR and saturates at all-ones.
- When undefined, the port and the counter do not exist.

Decomposition:
- Package vau_pkg: state enum, opcode constants (OP_ADD, OP_SUB, OP_MUL, ...), MAX_DIM and derived IDX_W=$clog2(MAX_DIM*MAX_DIM).
- One sub-module, vau_elem_counter: row/col/idx counters with a last-element flag.

Test Plan:
- 2x3 OP_ADD, bases A=0x00, B=0x20, C=0x40, ALU latency 2 -> six WRs at 0x40..0x45 in order; done after 1+6*7+1=44 cycles; no err.
- 12x12 command -> 144 WR strobes, final mem_addr=base_c+143; idx wraps cleanly; busy high throughout.
- cmd_rows=0 or cmd_cols=13 or cmd_op=NUM_OPS -> err pulse 1 cycle after accept; no alu_load, alu_start or mem_we.
- alu_done withheld -> err after exactly TIMEOUT cycles in WAIT; alu_rst pulse follows; cmd_ready returns.
- abort asserted in the same cycle as alu_done on element 3 -> no WR for that element; err pulse; IDLE within 2 cycles.
- rst_n asserted mid-WAIT -> all outputs immediately at reset values; the next command runs normally. With VAU_CYCLE_COUNT_EN, the 2x3 case reads cycle_count=44.
